// File: rtl/eth_frame_sender_if.sv
// Header and payload bus between eth_frame_sender and eth_axis_tx.
// master = frame sender side, slave = eth_axis_tx side.
interface eth_frame_sender_if;
    logic        s_eth_hdr_valid;
    logic        s_eth_hdr_ready;
    logic [47:0] s_eth_dest_mac;
    logic [47:0] s_eth_src_mac;
    logic [15:0] s_eth_type;
    logic [7:0]  s_eth_payload_axis_tdata;
    logic        s_eth_payload_axis_tvalid;
    logic        s_eth_payload_axis_tlast;
    logic        s_eth_payload_axis_tuser;
    logic        s_eth_payload_axis_tready;

    modport master (
        output s_eth_hdr_valid,
        input  s_eth_hdr_ready,
        output s_eth_dest_mac,
        output s_eth_src_mac,
        output s_eth_type,
        output s_eth_payload_axis_tdata,
        output s_eth_payload_axis_tvalid,
        output s_eth_payload_axis_tlast,
        output s_eth_payload_axis_tuser,
        input  s_eth_payload_axis_tready
    );

    modport slave (
        input  s_eth_hdr_valid,
        output s_eth_hdr_ready,
        input  s_eth_dest_mac,
        input  s_eth_src_mac,
        input  s_eth_type,
        input  s_eth_payload_axis_tdata,
        input  s_eth_payload_axis_tvalid,
        input  s_eth_payload_axis_tlast,
        input  s_eth_payload_axis_tuser,
        output s_eth_payload_axis_tready
    );
endinterface

// File: rtl/eth_frame_sender.sv
// Buffers a byte stream and issues header + payload to eth_axis_tx.
// Define ETH_FRAME_SENDER_PAD_EN to zero-pad short frames to MIN_PAYLOAD.
module eth_frame_sender #(
    parameter int DEPTH       = 16,
    parameter int MIN_PAYLOAD = 46
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_last,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [47:0]              cfg_dest_mac,
    input  logic [47:0]              cfg_src_mac,
    input  logic [15:0]              cfg_type,
    input  logic                     busy,
    eth_frame_sender_if.master       tx,
    output logic [15:0]              frame_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MIN_PAYLOAD < 1) begin : g_bad_param
        $error("eth_frame_sender: invalid DEPTH or MIN_PAYLOAD");
    end

`ifdef ETH_FRAME_SENDER_PAD_EN
    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, PAD} state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;
`endif

    state_t state, state_n;

    logic [8:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        rdy_q;
    logic        full, empty;
    logic [8:0]  head;
    logic        wr_en, rd_en;
    logic        beat, done;
    logic [15:0] byte_cnt;
    logic        hdr_valid, tvalid, tlast;
    logic [7:0]  tdata;
    logic [47:0] dest_q, src_q;
    logic [15:0] type_q;

    assign fifo_level = wr_ptr - rd_ptr;
    assign full       = (fifo_level == FULL_LVL);
    assign empty      = (fifo_level == '0);
    assign head       = mem[rd_ptr[AW-1:0]];
    // in_ready stays low until the first clock after reset releases
    assign in_ready   = rdy_q && !full;
    assign wr_en      = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

`ifdef ETH_FRAME_SENDER_PAD_EN
    logic short_frame;
    assign short_frame = ({1'b0, byte_cnt} + 17'd1) < 17'(MIN_PAYLOAD);
`endif

    always_comb begin
        state_n   = state;
        hdr_valid = 1'b0;
        tvalid    = 1'b0;
        tdata     = 8'h00;
        tlast     = 1'b0;
        rd_en     = 1'b0;
        beat      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && !busy) state_n = HDR;
            end
            HDR: begin
                hdr_valid = 1'b1;
                if (tx.s_eth_hdr_ready) state_n = PAYLOAD;
            end
            PAYLOAD: begin
                tvalid = !empty;
                if (!empty) begin
                    tdata = head[7:0];
                    tlast = head[8];
                end
                rd_en = !empty && tx.s_eth_payload_axis_tready;
                beat  = rd_en;
                if (rd_en && head[8]) begin
`ifdef ETH_FRAME_SENDER_PAD_EN
                    if (short_frame) begin
                        tlast   = 1'b0;
                        state_n = PAD;
                    end else begin
                        done    = 1'b1;
                        state_n = IDLE;
                    end
`else
                    done    = 1'b1;
                    state_n = IDLE;
`endif
                end
            end
`ifdef ETH_FRAME_SENDER_PAD_EN
            PAD: begin
                tvalid = 1'b1;
                tlast  = (byte_cnt == 16'(MIN_PAYLOAD - 1));
                beat   = tx.s_eth_payload_axis_tready;
                if (beat && tlast) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            frame_count <= '0;
            dest_q      <= '0;
            src_q       <= '0;
            type_q      <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n == HDR) begin
                dest_q <= cfg_dest_mac;
                src_q  <= cfg_src_mac;
                type_q <= cfg_type;
            end
            if (done) begin
                byte_cnt    <= '0;
                frame_count <= frame_count + 16'd1;
            end else if (beat && byte_cnt != 16'hFFFF) begin
                byte_cnt <= byte_cnt + 16'd1;
            end
        end
    end

    assign tx.s_eth_hdr_valid           = hdr_valid;
    assign tx.s_eth_dest_mac            = dest_q;
    assign tx.s_eth_src_mac             = src_q;
    assign tx.s_eth_type                = type_q;
    assign tx.s_eth_payload_axis_tdata  = tdata;
    assign tx.s_eth_payload_axis_tvalid = tvalid;
    assign tx.s_eth_payload_axis_tlast  = tlast;
    assign tx.s_eth_payload_axis_tuser  = 1'b0;
endmodule
